// File: rtl/mont_conv_pkg.sv
// Shared types and constants for the Montgomery domain converter.
package mont_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_TO_MONT   = 1'b1;
  localparam logic DIR_FROM_MONT = 1'b0;

  // Width of m_size: wide enough to hold NBITS and out-of-range requests.
  function automatic int msize_w(input int nbits);
    return $clog2(nbits) + 3;
  endfunction

endpackage

// File: rtl/montgomery_domain_conv_step.sv
// One conversion step, combinational: modular doubling (into the domain)
// or odd-fixup halving (out of the domain) on an NBITS+1 wide value.
module mont_conv_step
  import mont_conv_pkg::*;
#(
  parameter int NBITS = 2048
) (
  input  logic             dir,
  input  logic [NBITS:0]   t_in,
  input  logic [NBITS-1:0] m,
  output logic [NBITS:0]   t_out
);

  logic [NBITS:0] m_ext;
  logic [NBITS:0] dbl;
  logic [NBITS:0] dbl_red;
  logic [NBITS:0] sum;
  logic [NBITS:0] half;

  assign m_ext   = {1'b0, m};
  assign dbl     = t_in << 1;
  assign dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
  // For t < m the sum stays below 2^(NBITS+1), so no carry is lost.
  assign sum     = t_in[0] ? (t_in + m_ext) : t_in;
  assign half    = sum >> 1;
  assign t_out   = (dir == DIR_FROM_MONT) ? half : dbl_red;

endmodule

// File: rtl/montgomery_domain_conv.sv
// Montgomery domain converter: y = a*R mod m or a*R^-1 mod m with R = 2^k,
// PBITS steps per clock. Define MONT_CONV_ABORT_EN to add the abort_p input.
//
// state | meaning
// IDLE  | waiting for enable_p; y and err hold the last completion
// RUN   | stepping the intermediate value, counter holds steps remaining
// DONE  | publish y (unless rejected), pulse done_irq_p, return to IDLE
module montgomery_domain_conv
  import mont_conv_pkg::*;
#(
  parameter int NBITS = 2048,
  parameter int PBITS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_p,
`ifdef MONT_CONV_ABORT_EN
  input  logic                        abort_p,
`endif
  input  logic                        dir,
  input  logic [NBITS-1:0]            a,
  input  logic [NBITS-1:0]            m,
  input  logic [msize_w(NBITS)-1:0]   m_size,
  output logic [NBITS-1:0]            y,
  output logic                        busy,
  output logic                        done_irq_p,
  output logic                        err
);

  localparam int            MW    = msize_w(NBITS);
  localparam logic [MW-1:0] PSTEP = MW'(PBITS);
  localparam logic [MW-1:0] KMAX  = MW'(NBITS);

  state_t           state;
  logic [MW-1:0]    cnt;
  logic [NBITS:0]   t;
  logic [NBITS-1:0] m_q;
  logic             dir_q;
  logic             err_pend;

  logic [NBITS:0]   t_chain  [0:PBITS];
  logic [NBITS:0]   step_out [0:PBITS-1];
  logic [MW-1:0]    step_n;
  logic             start_bad;

  assign t_chain[0] = t;

  // Stages past the remaining count pass through, so the last stage always
  // carries the value after min(PBITS, cnt) steps.
  for (genvar i = 0; i < PBITS; i++) begin : g_step
    mont_conv_step #(.NBITS(NBITS)) u_step (
      .dir   (dir_q),
      .t_in  (t_chain[i]),
      .m     (m_q),
      .t_out (step_out[i])
    );
    assign t_chain[i+1] = (MW'(i) < cnt) ? step_out[i] : t_chain[i];
  end

  assign step_n    = (cnt >= PSTEP) ? PSTEP : cnt;
  assign start_bad = ~m[0] | (m_size == '0) | (m_size > KMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      t          <= '0;
      m_q        <= '0;
      dir_q      <= DIR_TO_MONT;
      err_pend   <= 1'b0;
      y          <= '0;
      busy       <= 1'b0;
      done_irq_p <= 1'b0;
      err        <= 1'b0;
    end else begin
      done_irq_p <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_p) begin
            m_q      <= m;
            dir_q    <= dir;
            cnt      <= m_size;
            t        <= {1'b0, a};
            err      <= 1'b0;
            err_pend <= start_bad;
            busy     <= 1'b1;
            state    <= start_bad ? DONE : RUN;
          end
        end
        RUN: begin
`ifdef MONT_CONV_ABORT_EN
          if (abort_p) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            t   <= t_chain[PBITS];
            cnt <= cnt - step_n;
            if (cnt <= PSTEP) state <= DONE;
          end
`else
          t   <= t_chain[PBITS];
          cnt <= cnt - step_n;
          if (cnt <= PSTEP) state <= DONE;
`endif
        end
        DONE: begin
          done_irq_p <= 1'b1;
          busy       <= 1'b0;
          err        <= err_pend;
          if (!err_pend) y <= t[NBITS-1:0];
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_domain_conv.sv
// Scoreboard bench for montgomery_domain_conv: one PBITS=1 and one PBITS=4
// instance; expectations from an arithmetic reference model.
module tb_montgomery_domain_conv;

  localparam int NB = 8;
  localparam int KW = $clog2(NB) + 3;

  typedef struct {
    logic [NB-1:0] y;
    logic          err;
    int            lat;
    int            start;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en1 = 1'b0, en4 = 1'b0;
  logic          abort1 = 1'b0, abort4 = 1'b0;
  logic          dir = 1'b1;
  logic [NB-1:0] a = '0, m = '0;
  logic [KW-1:0] m_size = '0;
  logic [NB-1:0] y1, y4;
  logic          busy1, busy4, done1, done4, err1, err4;

  exp_t          q1[$], q4[$];
  logic [NB-1:0] last_y1 = '0, last_y4 = '0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  montgomery_domain_conv #(.NBITS(NB), .PBITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_p(en1),
`ifdef MONT_CONV_ABORT_EN
    .abort_p(abort1),
`endif
    .dir(dir), .a(a), .m(m), .m_size(m_size),
    .y(y1), .busy(busy1), .done_irq_p(done1), .err(err1)
  );

  montgomery_domain_conv #(.NBITS(NB), .PBITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable_p(en4),
`ifdef MONT_CONV_ABORT_EN
    .abort_p(abort4),
`endif
    .dir(dir), .a(a), .m(m), .m_size(m_size),
    .y(y4), .busy(busy4), .done_irq_p(done4), .err(err4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: into domain is a*2^k mod m; out of domain is the y < m
  // satisfying y*2^k mod m == a mod m.
  function automatic logic [NB-1:0] ref_conv(input logic d, input logic [NB-1:0] av,
                                            input logic [NB-1:0] mv, input int k);
    longint r;
    r = 0;
    if (d) begin
      r = (longint'(av) << k) % longint'(mv);
    end else begin
      for (longint c = 0; c < longint'(mv); c++)
        if (((c << k) % longint'(mv)) == (longint'(av) % longint'(mv))) begin
          r = c;
          break;
        end
    end
    return r[NB-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) check_eq("spurious_done1", 32'(done1), 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check_eq("y1", 32'(y1), 32'(e.y));
        check_eq("err1", 32'(err1), 32'(e.err));
        check_eq("lat1", 32'(cyc - e.start - 1), 32'(e.lat));
        check_eq("busy1_at_done", 32'(busy1), 0);
      end
    end
    if (rst_n && done4) begin
      if (q4.size() == 0) check_eq("spurious_done4", 32'(done4), 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        check_eq("y4", 32'(y4), 32'(e.y));
        check_eq("err4", 32'(err4), 32'(e.err));
        check_eq("lat4", 32'(cyc - e.start - 1), 32'(e.lat));
      end
    end
  end

  task automatic kick(input bit sel4, input logic d, input logic [NB-1:0] av,
                      input logic [NB-1:0] mv, input int k);
    exp_t e;
    int   p;
    p = sel4 ? 4 : 1;
    @(negedge clk);
    dir = d; a = av; m = mv; m_size = KW'(k);
    e.err   = (mv[0] == 1'b0) || (k == 0) || (k > NB);
    e.lat   = e.err ? 1 : (k + p - 1) / p + 1;
    e.start = cyc;
    if (sel4) begin
      e.y = e.err ? last_y4 : ref_conv(d, av, mv, k);
      last_y4 = e.y;
      q4.push_back(e);
      en4 = 1'b1;
    end else begin
      e.y = e.err ? last_y1 : ref_conv(d, av, mv, k);
      last_y1 = e.y;
      q1.push_back(e);
      en1 = 1'b1;
    end
    @(negedge clk);
    en1 = 1'b0; en4 = 1'b0;
    check_eq(sel4 ? "busy4_started" : "busy1_started", 32'(sel4 ? busy4 : busy1), 1);
  endtask

  task automatic drain(input bit sel4);
    for (int i = 0; i < 40 && (sel4 ? q4.size() : q1.size()) != 0; i++) @(negedge clk);
    check_eq(sel4 ? "drain4" : "drain1", 32'(sel4 ? q4.size() : q1.size()), 0);
    @(negedge clk);
  endtask

  task automatic run(input bit sel4, input logic d, input logic [NB-1:0] av,
                     input logic [NB-1:0] mv, input int k);
    kick(sel4, d, av, mv, k);
    drain(sel4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_y", 32'(y1), 0);
    check_eq("rst_busy", 32'(busy1), 0);
    check_eq("rst_done", 32'(done1), 0);
    check_eq("rst_err", 32'(err1), 0);
    rst_n = 1'b1;

    run(0, 1'b1, 8'd5, 8'd13, 4);     // -> 2, 5 cycles
    run(0, 1'b0, 8'd2, 8'd13, 4);     // -> 5
    run(0, 1'b1, 8'd0, 8'd13, 4);
    run(0, 1'b0, 8'd0, 8'd13, 4);
    run(0, 1'b1, 8'd254, 8'd255, 8);  // -> 254
    run(1, 1'b1, 8'd254, 8'd255, 8);  // 3 cycles at PBITS=4
    run(1, 1'b0, 8'd7, 8'd11, 5);
    run(1, 1'b1, 8'd200, 8'd201, 7);
    run(0, 1'b1, 8'd5, 8'd12, 4);     // even modulus
    run(0, 1'b1, 8'd5, 8'd13, 0);     // k = 0
    run(0, 1'b1, 8'd5, 8'd13, 9);     // k > NBITS
    run(1, 1'b0, 8'd3, 8'd13, 0);
    run(0, 1'b0, 8'd9, 8'd13, 3);     // err cleared by a good start
    for (int i = 0; i < 4; i++)
      run(i[0], i[1], 8'($urandom_range(0, 250)), 8'd251, $urandom_range(1, 8));

    // enable_p re-pulsed mid-RUN with a different operand is ignored
    kick(0, 1'b1, 8'd5, 8'd13, 4);
    @(negedge clk);
    a = 8'd99; en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    drain(0);

    // reset in the middle of a run
    kick(0, 1'b1, 8'd254, 8'd255, 8);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    q1.delete();
    check_eq("midrst_y", 32'(y1), 0);
    check_eq("midrst_busy", 32'(busy1), 0);
    check_eq("midrst_err", 32'(err1), 0);
    check_eq("midrst_y4", 32'(y4), 0);
    rst_n = 1'b1;
    last_y1 = '0; last_y4 = '0;
    repeat (14) @(negedge clk);

`ifdef MONT_CONV_ABORT_EN
    run(0, 1'b1, 8'd5, 8'd13, 4);
    kick(0, 1'b1, 8'd254, 8'd255, 8);
    @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    q1.delete();
    last_y1 = 8'd2;
    check_eq("abort_busy", 32'(busy1), 0);
    check_eq("abort_y", 32'(y1), 32'(last_y1));
    repeat (14) @(negedge clk);
    run(0, 1'b0, 8'd2, 8'd13, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/montgomery_domain_conv.md
MONTGOMERY_DOMAIN_CONV -- requirements
Module: montgomery_domain_conv

Interface
REQ-001 SHALL have parameter NBITS, default 2048, meaning the operand and modulus width in bits.
REQ-002 SHALL have parameter PBITS, default 1, meaning the number of conversion steps performed per clock (1..NBITS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port enable_p, input, 1 bit: start pulse.
REQ-006 SHALL have port dir, input, 1 bit: 1 = into Montgomery domain (a*R mod m); 0 = out of Montgomery domain (a*R^-1 mod m).
REQ-007 SHALL have ports a and m, each input, NBITS wide: operand and odd modulus.
REQ-008 SHALL have port m_size, input, $clog2(NBITS)+3 bits: k, the bit length of m; R = 2^k.
REQ-009 SHALL have port y, output, NBITS wide: result.
REQ-010 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-011 SHALL have port done_irq_p, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: set with done_irq_p when the request is rejected.

Function
REQ-013 SHALL be a state machine with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with enable_p=1, capture a, m, m_size and dir, load the step counter with k, and go to RUN when the parameters are valid.
REQ-015 SHALL treat m[0]=0, k=0 or k>NBITS as invalid: go to DONE with err=1, leave y unchanged and perform no steps.
REQ-016 SHALL, in dir=1, perform each step as t = 2t, then t = t - m if t >= m; the intermediate value is NBITS+1 bits wide.
REQ-017 SHALL, in dir=0, perform each step as t = t + m if t is odd, then t = t >> 1; the intermediate value is NBITS+1 bits wide.
REQ-018 SHALL, in RUN, perform min(PBITS, remaining) steps per cycle and go to DONE when the counter reaches 0.
REQ-019 SHALL have latency ceil(k/PBITS)+1 cycles: with the enable_p edge at E0, y is updated and done_irq_p is high for exactly one cycle after edge E0+ceil(k/PBITS)+1.
REQ-020 SHALL return from DONE to IDLE after one cycle; busy is high in RUN and DONE.
REQ-021 SHALL ignore enable_p while busy, and SHALL accept enable_p in the cycle after DONE.
REQ-022 SHALL hold y stable between completions; err is cleared on the next accepted start.
REQ-023 SHALL produce a result < m for any a < m; behaviour for a >= m is unspecified, but the block does not hang.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set y=0, busy=0, done_irq_p=0, err=0 and state=IDLE, including mid-RUN; the interrupted conversion produces no done_irq_p.

Configuration
REQ-025 SHALL, with MONT_CONV_ABORT_EN defined, add input abort_p; abort_p=1 in RUN moves the block to IDLE on the next edge with no done_irq_p and y unchanged; abort_p in IDLE has no effect.
REQ-026 SHALL, without MONT_CONV_ABORT_EN, have no abort_p port and behave as REQ-013..REQ-024.

Structure
REQ-027 SHALL take its state enum, the DIR_TO_MONT/DIR_FROM_MONT constants and the m_size width function from shared package mont_conv_pkg.
REQ-028 SHALL implement one doubling/halving step in sub-module mont_conv_step (combinational, dir-selected) and instantiate it PBITS times in a chain.

Verification
REQ-029 SHALL be tested with NBITS=8, PBITS=1, m=13, k=4, dir=1, a=5 -> y=2, err=0, done_irq_p exactly 5 cycles after enable_p.
REQ-030 SHALL be tested with m=13, k=4, dir=0, a=2 -> y=5 (round trip); with a=0 -> y=0 in either direction.
REQ-031 SHALL be tested with m=255, k=8, dir=1, a=254 -> y=254; with PBITS=4 -> done_irq_p after 3 cycles.
REQ-032 SHALL be tested with m=12 (even) or k=0 -> done_irq_p after 1 cycle, err=1, y unchanged.
REQ-033 SHALL be tested with enable_p re-pulsed mid-RUN -> ignored and result unchanged; rst_n=0 mid-RUN -> all outputs 0 and no done_irq_p.
REQ-034 SHALL be tested, with MONT_CONV_ABORT_EN defined, with abort_p at cycle 2 of a k=8 run -> busy=0 next cycle, no done_irq_p, y holds its previous value.
